matmul_seq: RTL and testbench

Sequential, parametrised matrix-multiply engine; next generation of the combinational array multiplier. Computes C = A·B, or C = C + A·B in accumulate mode, using LANES column MAC lanes time-multiplexed over the shared dimension and the output column groups. It also supports a runtime signed/unsigned select and valid/ready handshakes on input and output. It sits between the operand buffers and the result sink in the accelerator datapath.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_seq_mac_column.sv | 38 +++
 rtl/matmul_seq.sv | 151 +++++++++++++++
 tb/tb_matmul_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helper for the sequential matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Result element width: full product, growth over the shared dimension,
  // plus guard bits for repeated accumulate jobs.
  function automatic int wc(input int wa, input int wb, input int c1, input int guard);
    return wa + wb + $clog2(c1) + guard;
  endfunction

endpackage

// File: rtl/matmul_seq_mac_column.sv
// One output column: R1 parallel multiply-accumulates of A[r][k] * B[k][j]
// onto the running C column, with runtime signed/unsigned operand extension.
module mac_column
  import matmul_pkg::*;
#(
  parameter int R1  = 8,
  parameter int W_A = 8,
  parameter int W_B = 8,
  parameter int W_C = 23
) (
  input  logic [R1-1:0][W_A-1:0] a_i,
  input  logic [W_B-1:0]         b_i,
  input  logic                   signed_mode_i,
  input  logic                   clr_i,
  input  logic [R1-1:0][W_C-1:0] c_i,
  output logic [R1-1:0][W_C-1:0] c_o
);

  logic [W_C-1:0] b_ext;
  logic           b_fill;

  assign b_fill = signed_mode_i & b_i[W_B-1];
  assign b_ext  = {{(W_C-W_B){b_fill}}, b_i};

  // Products are taken at full W_C width so that signed operands wrap
  // correctly modulo 2^W_C without a separate signed multiplier.
  for (genvar r = 0; r < R1; r++) begin : g_row
    logic           a_fill;
    logic [W_C-1:0] a_ext;
    logic [W_C-1:0] base;

    assign a_fill = signed_mode_i & a_i[r][W_A-1];
    assign a_ext  = {{(W_C-W_A){a_fill}}, a_i[r]};
    assign base   = clr_i ? '0 : c_i[r];
    assign c_o[r] = base + a_ext * b_ext;
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential matrix multiply C = A*B (or C += A*B), LANES columns per cycle,
// stepping the shared index k fastest and the column group g slowest.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter  int R1        = 8,
  parameter  int C1        = 6,
  parameter  int C2        = 8,
  parameter  int LANES     = 2,
  parameter  int W_A       = 8,
  parameter  int W_B       = 8,
  parameter  int ACC_GUARD = 4,
  localparam int W_C       = wc(W_A, W_B, C1, ACC_GUARD)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cen,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [R1-1:0][C1-1:0][W_A-1:0] A,
  input  logic [C1-1:0][C2-1:0][W_B-1:0] B,
  input  logic                           signed_mode,
  input  logic                           acc_en,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [R1-1:0][C2-1:0][W_C-1:0] C,
  output logic                           busy
);

  localparam int NG = C2 / LANES;
  localparam int KW = (C1 > 1) ? $clog2(C1) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  if (C2 % LANES != 0) begin : g_bad_lanes
    $error("matmul_seq: C2 must be a multiple of LANES");
  end

  state_t                         state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [GW-1:0]                  g_q, g_d;
  logic [R1-1:0][C1-1:0][W_A-1:0] a_q;
  logic [C1-1:0][C2-1:0][W_B-1:0] b_q;
  logic                           sgn_q, acc_q;
  logic [R1-1:0][C2-1:0][W_C-1:0] c_q, c_d;

  logic                           accept;
  logic                           clr;
  logic [R1-1:0][W_A-1:0]         a_col;
  logic [LANES-1:0][W_B-1:0]      b_row;
  logic [LANES-1:0][R1-1:0][W_C-1:0] mac_in, mac_out;

  assign accept  = cen && s_valid && (state_q == IDLE);
  assign clr     = (k_q == '0) && !acc_q;
  assign s_ready = (state_q == IDLE);
  assign m_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign C       = c_q;

  // Route A column k and the current group's B row slice / C columns to the lanes.
  always_comb begin
    mac_in = '0;
    b_row  = '0;
    for (int r = 0; r < R1; r++) a_col[r] = a_q[r][k_q];
    for (int j = 0; j < C2; j++) begin
      if (GW'(j / LANES) == g_q) begin
        b_row[j % LANES] = b_q[k_q][j];
        for (int r = 0; r < R1; r++) mac_in[j % LANES][r] = c_q[r][j];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_column #(.R1(R1), .W_A(W_A), .W_B(W_B), .W_C(W_C)) u_mac (
      .a_i           (a_col),
      .b_i           (b_row[l]),
      .signed_mode_i (sgn_q),
      .clr_i         (clr),
      .c_i           (mac_in[l]),
      .c_o           (mac_out[l])
    );
  end

  // Write lane results back into the active column group while computing.
  always_comb begin
    c_d = c_q;
    if (cen && state_q == COMPUTE) begin
      for (int j = 0; j < C2; j++) begin
        if (GW'(j / LANES) == g_q) begin
          for (int r = 0; r < R1; r++) c_d[r][j] = mac_out[j % LANES][r];
        end
      end
    end
  end

  // Control FSM and k/g counters; everything holds while cen is low.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    if (cen) begin
      case (state_q)
        IDLE: if (s_valid) begin
          state_d = COMPUTE;
          k_d     = '0;
          g_d     = '0;
        end
        COMPUTE: begin
          if (k_q == KW'(C1 - 1)) begin
            k_d = '0;
            if (g_q == GW'(NG - 1)) begin
              g_d     = '0;
              state_d = DONE;
            end else begin
              g_d = g_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DONE:    if (m_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters, result and latched operands/modes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      g_q     <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      c_q     <= c_d;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= signed_mode;
        acc_q <= acc_en;
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: directed vector table, handshake /
// cen / reset sequences, and randomized jobs against a reference model.
module tb_matmul_seq;
  import matmul_pkg::*;

  localparam int R1 = 8, C1 = 6, C2 = 8, LANES = 2, W_A = 8, W_B = 8, ACC_GUARD = 4;
  localparam int W_C = wc(W_A, W_B, C1, ACC_GUARD);
  localparam int N   = C1 * C2 / LANES;

  typedef logic [R1-1:0][C1-1:0][W_A-1:0] a_t;
  typedef logic [C1-1:0][C2-1:0][W_B-1:0] b_t;
  typedef logic [R1-1:0][C2-1:0][W_C-1:0] c_t;

  typedef struct {
    string nm;
    a_t    a;
    b_t    b;
    logic  sgn;
    logic  acc;
    c_t    exp;
  } vec_t;

  logic clk = 1'b0, rstn, cen, s_valid, s_ready, m_valid, m_ready, busy;
  logic sgn_s, acc_s;
  a_t   a_s;
  b_t   b_s;
  c_t   c_s;

  int checks = 0, errors = 0;
  int cyc_cnt = 0;
  c_t sb[$];
  c_t mdl_c = '0;
  c_t exp_c;

  matmul_seq #(.R1(R1), .C1(C1), .C2(C2), .LANES(LANES), .W_A(W_A), .W_B(W_B),
               .ACC_GUARD(ACC_GUARD)) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .s_valid(s_valid), .s_ready(s_ready),
    .A(a_s), .B(b_s), .signed_mode(sgn_s), .acc_en(acc_s), .m_valid(m_valid),
    .m_ready(m_ready), .C(c_s), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic c_t model(input c_t prev, input a_t a, input b_t b, input logic sgn,
                               input logic acc);
    c_t res;
    for (int r = 0; r < R1; r++)
      for (int j = 0; j < C2; j++) begin
        longint s = acc ? longint'(prev[r][j]) : 64'sd0;
        for (int k = 0; k < C1; k++) begin
          longint x = sgn ? longint'($signed(a[r][k])) : longint'(a[r][k]);
          longint y = sgn ? longint'($signed(b[k][j])) : longint'(b[k][j]);
          s += x * y;
        end
        res[r][j] = s[W_C-1:0];
      end
    return res;
  endfunction

  task automatic chk1(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkC(input string nm, input c_t act, input c_t exp);
    bit shown = 0;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int r = 0; r < R1; r++)
        for (int j = 0; j < C2; j++)
          if (!shown && act[r][j] !== exp[r][j]) begin
            shown = 1;
            $display("FAIL %s: C[%0d][%0d] got %h expected %h", nm, r, j, act[r][j], exp[r][j]);
          end
    end
  endtask

  // Scoreboard: push model result on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (rstn && cen) begin
      if (s_valid && s_ready) begin
        mdl_c = model(mdl_c, a_s, b_s, sgn_s, acc_s);
        sb.push_back(mdl_c);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: result with no pending job");
        end else begin
          exp_c = sb.pop_front();
          chkC("sb_result", c_s, exp_c);
        end
      end
    end
  end

  // Present a job and hold it until accepted; returns the cycle stamp of the accept edge.
  task automatic do_accept(input a_t a, input b_t b, input logic sgn, input logic acc,
                           output int t0);
    int n = 0;
    a_s = a; b_s = b; sgn_s = sgn; acc_s = acc; s_valid = 1'b1;
    @(negedge clk);
    while (!(s_ready && cen) && n < 100) begin @(negedge clk); n++; end
    if (!(s_ready && cen)) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_ready got %0d expected 1", s_ready);
    end
    @(posedge clk); #1;
    t0 = cyc_cnt;
    s_valid = 1'b0;
  endtask

  // Wait for m_valid (bounded); latency measured in edges from the accept edge.
  task automatic wait_mv(input int t0, output int lat);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 300) begin @(negedge clk); n++; end
    if (!m_valid) begin
      checks++; errors++;
      $display("FAIL mvalid_timeout: m_valid got 0 expected 1");
    end
    lat = cyc_cnt - t0;
  endtask

  function automatic a_t rnd_a();
    a_t a;
    for (int r = 0; r < R1; r++) for (int k = 0; k < C1; k++) a[r][k] = W_A'($urandom);
    return a;
  endfunction

  function automatic b_t rnd_b();
    b_t b;
    for (int k = 0; k < C1; k++) for (int j = 0; j < C2; j++) b[k][j] = W_B'($urandom);
    return b;
  endfunction

  vec_t vecs[5];
  a_t   id_a, ff_a;
  b_t   id_b, ff_b;
  c_t   id_c, id2_c, neg_c, pos_c, zero_c;
  int   t0, lat, jobs, guard;
  bit   took;

  initial begin
    // Hand-derived reference matrices for the directed table.
    zero_c = '0;
    for (int r = 0; r < R1; r++)
      for (int k = 0; k < C1; k++) begin
        id_a[r][k] = (r == k) ? 8'd1 : 8'd0;
        ff_a[r][k] = 8'hFF;
      end
    for (int k = 0; k < C1; k++)
      for (int j = 0; j < C2; j++) begin
        id_b[k][j] = W_B'(j + 1);
        ff_b[k][j] = 8'h02;
      end
    for (int r = 0; r < R1; r++)
      for (int j = 0; j < C2; j++) begin
        id_c[r][j]  = (r < 6) ? W_C'(j + 1) : '0;
        id2_c[r][j] = (r < 6) ? W_C'(2 * (j + 1)) : '0;
        neg_c[r][j] = 23'h7FFFF4;
        pos_c[r][j] = W_C'(3060);
      end
    vecs[0] = '{"identity",       id_a, id_b, 1'b1, 1'b0, id_c};
    vecs[1] = '{"accumulate",     id_a, id_b, 1'b1, 1'b1, id2_c};
    vecs[2] = '{"overwrite",      id_a, id_b, 1'b1, 1'b0, id_c};
    vecs[3] = '{"signed_ff",      ff_a, ff_b, 1'b1, 1'b0, neg_c};
    vecs[4] = '{"unsigned_ff",    ff_a, ff_b, 1'b0, 1'b0, pos_c};

    rstn = 1'b0; cen = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    a_s = '0; b_s = '0; sgn_s = 1'b0; acc_s = 1'b0;
    #12;
    chkC("reset_C", c_s, zero_c);
    chk1("reset_m_valid", m_valid, 0);
    chk1("reset_s_ready", s_ready, 1);
    chk1("reset_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1; cen = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      do_accept(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].acc, t0);
      wait_mv(t0, lat);
      chk1({vecs[i].nm, "_latency"}, lat, N);
      chkC(vecs[i].nm, c_s, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Backpressure: result held, new operands ignored while m_ready is low.
    m_ready = 1'b0;
    do_accept(ff_a, ff_b, 1'b1, 1'b0, t0);
    wait_mv(t0, lat);
    a_s = id_a; b_s = id_b; sgn_s = 1'b0; acc_s = 1'b1; s_valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk1("bp_m_valid", m_valid, 1);
    chk1("bp_s_ready", s_ready, 0);
    chkC("bp_C_held", c_s, neg_c);
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk1("bp_released", s_ready, 1);

    // cen dropped for 5 cycles mid-compute delays completion by exactly 5.
    do_accept(id_a, id_b, 1'b1, 1'b0, t0);
    repeat (5) @(posedge clk);
    #1 cen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("cen_busy", busy, 1);
    chk1("cen_m_valid", m_valid, 0);
    repeat (2) @(posedge clk);
    #1 cen = 1'b1;
    wait_mv(t0, lat);
    chk1("cen_latency", lat, N + 5);
    chkC("cen_result", c_s, id_c);
    @(posedge clk); #1;

    // Asynchronous reset at compute cycle 12.
    do_accept(ff_a, ff_b, 1'b0, 1'b1, t0);
    repeat (12) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chkC("rst_mid_C", c_s, zero_c);
    chk1("rst_mid_m_valid", m_valid, 0);
    chk1("rst_mid_s_ready", s_ready, 1);
    sb.delete();
    mdl_c = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    do_accept(id_a, id_b, 1'b1, 1'b0, t0);
    wait_mv(t0, lat);
    chk1("post_rst_latency", lat, N);
    chkC("post_rst_result", c_s, id_c);
    @(posedge clk); #1;

    // Random jobs with random modes, cen and m_ready.
    jobs = 0; guard = 0; took = 0; s_valid = 1'b0;
    while (jobs < 200 && guard < 50000) begin
      @(posedge clk); #1;
      guard++;
      cen     = ($urandom_range(0, 4) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if (!s_valid || took) begin
        a_s = rnd_a(); b_s = rnd_b();
        sgn_s = 1'($urandom_range(0, 1)); acc_s = 1'($urandom_range(0, 1));
        s_valid = 1'b1; took = 0;
      end
      @(negedge clk);
      if (s_valid && s_ready && cen) begin took = 1; jobs++; end
    end
    chk1("random_jobs", jobs, 200);

    // Drain the last result.
    @(posedge clk); #1;
    s_valid = 1'b0; cen = 1'b1; m_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || !s_ready) && guard < 200) begin @(posedge clk); #1; guard++; end
    chk1("drain_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
